// File: rtl/uart_echo_ctrl_if.sv
// Byte-stream handshake between the UART RX/TX blocks and the echo controller.
// The RX side presents strobed bytes; the TX side drains the controller with valid/ready.
interface uart_echo_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_echo_ctrl.sv
// Echo FIFO plus in-band escape parser for the UART top level.
// Mode changes wait until the echo path is empty, so every byte leaves at one setting.
module uart_echo_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int MODE_W     = 4,
  parameter int MODE_RESET = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_echo_ctrl_if.slave             bus,
  output logic [MODE_W-1:0]           mode,
  output logic                        armed,
  output logic                        cmd_pending,
  output logic                        echo_en,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  localparam logic [7:0] BYTE_ESC     = 8'hFF;
  localparam logic [7:0] BYTE_OVF_CLR = 8'hE0;
  localparam logic [7:0] BYTE_ECHO_OFF = 8'hE1;
  localparam logic [7:0] BYTE_ECHO_ON = 8'hE2;

  typedef enum logic {
    PS_IDLE,
    PS_ARMED
  } pstate_t;

  pstate_t           state_q, state_d;
  logic [MODE_W-1:0] pend_q;
  logic              pend_load;
  logic              cmd_pending_d;
  logic              echo_en_d;
  logic              ovf_clr;
  logic              is_esc;
  logic              is_mode_cmd;
  logic              apply;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push_req, push, pop, drop;

  // ---- FIFO handshake decode ----
  assign bus.tx_valid = (fifo_level != '0);
  assign bus.tx_data  = mem[rd_ptr];

  assign pop      = bus.tx_valid && bus.tx_ready;
  assign push_req = bus.rx_valid && echo_en;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && ((fifo_level < DEPTH_L) || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---- escape parser ----
  assign is_esc      = (bus.rx_data == BYTE_ESC);
  assign is_mode_cmd = (&bus.rx_data[7:MODE_W]) && !is_esc;
  assign apply       = cmd_pending && (fifo_level == '0) && !bus.rx_valid && !push;
  assign armed       = (state_q == PS_ARMED);

  always_comb begin
    state_d       = state_q;
    pend_load     = 1'b0;
    cmd_pending_d = cmd_pending;
    echo_en_d     = echo_en;
    ovf_clr       = 1'b0;
    if (bus.rx_valid) begin
      case (state_q)
        PS_IDLE: begin
          if (is_esc) begin
            state_d = PS_ARMED;
          end
        end
        PS_ARMED: begin
          state_d = PS_IDLE;
          if (is_esc) begin
            state_d = PS_ARMED;
          end else if (is_mode_cmd) begin
            pend_load     = 1'b1;
            cmd_pending_d = 1'b1;
          end else if (bus.rx_data == BYTE_OVF_CLR) begin
            ovf_clr = 1'b1;
          end else if (bus.rx_data == BYTE_ECHO_OFF) begin
            echo_en_d = 1'b0;
          end else if (bus.rx_data == BYTE_ECHO_ON) begin
            echo_en_d = 1'b1;
          end
        end
        default: state_d = PS_IDLE;
      endcase
    end
    if (apply) begin
      cmd_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_q <= bus.rx_data[MODE_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PS_IDLE;
      cmd_pending <= 1'b0;
      echo_en     <= 1'b1;
      overflow    <= 1'b0;
      mode        <= MODE_W'(MODE_RESET);
    end else begin
      state_q     <= state_d;
      cmd_pending <= cmd_pending_d;
      echo_en     <= echo_en_d;
      // A clear command wins over a drop of that same command byte.
      if (ovf_clr) begin
        overflow <= 1'b0;
      end else if (drop) begin
        overflow <= 1'b1;
      end
      if (apply) begin
        mode <= pend_q;
      end
    end
  end
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: directed bytes queue their expected echoes,
// a negedge monitor pops and compares each transmitted byte.
module tb_uart_echo_ctrl;
  localparam int DEPTH  = 4;
  localparam int MODE_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_echo_ctrl_if bus ();

  logic [MODE_W-1:0] mode;
  logic              armed;
  logic              cmd_pending;
  logic              echo_en;
  logic              overflow;
  logic [2:0]        fifo_level;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_echo_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .MODE_W     (MODE_W),
    .MODE_RESET (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mode        (mode),
    .armed       (armed),
    .cmd_pending (cmd_pending),
    .echo_en     (echo_en),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every accepted TX transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL echo_unexpected: got 0x%0h, expected no byte", bus.tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("echo_data", 32'(bus.tx_data), 32'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit echoed);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    if (echoed) exp_q.push_back(b);
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && fifo_level != 3'd0; i++) step();
    check(name, 32'(fifo_level), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_level",    32'(fifo_level),   32'd0);
    check("rst_mode",     32'(mode),         32'd1);
    check("rst_echo_en",  32'(echo_en),      32'd1);
    check("rst_armed",    32'(armed),        32'd0);
    check("rst_pending",  32'(cmd_pending),  32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);
    rst_n = 1'b1;
    step();

    // plain echo
    bus.tx_ready = 1'b1;
    send(8'h41, 1'b1);
    check("t1_tx_valid", 32'(bus.tx_valid), 32'd1);
    send(8'h42, 1'b1);
    wait_drain("t1_drain");

    // deferred mode change
    bus.tx_ready = 1'b0;
    send(8'hFF, 1'b1);
    check("t2_armed", 32'(armed), 32'd1);
    send(8'hF3, 1'b1);
    check("t2_pending", 32'(cmd_pending), 32'd1);
    check("t2_disarm",  32'(armed),       32'd0);
    check("t2_level",   32'(fifo_level),  32'd2);
    step();
    step();
    check("t2_mode_held", 32'(mode), 32'd1);
    bus.tx_ready = 1'b1;
    wait_drain("t2_drain");
    check("t2_mode_at_last_pop", 32'(mode), 32'd1);
    step();
    check("t2_mode_applied",  32'(mode),        32'd3);
    check("t2_pending_clear", 32'(cmd_pending), 32'd0);

    // overflow and its clear command
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i), i <= DEPTH);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    check("t3_overflow",   32'(overflow),   32'd1);
    send(8'hFF, 1'b0);
    check("t3_armed_full", 32'(armed), 32'd1);
    send(8'hE0, 1'b0);
    check("t3_ovf_cleared", 32'(overflow),   32'd0);
    check("t3_level_kept",  32'(fifo_level), 32'd4);
    bus.tx_ready = 1'b1;
    send(8'h77, 1'b1);
    check("t3_pushpop_level", 32'(fifo_level), 32'd4);
    check("t3_pushpop_ovf",   32'(overflow),   32'd0);
    wait_drain("t3_drain");

    // echo disable / enable
    send(8'hFF, 1'b1);
    send(8'hE1, 1'b1);
    check("t4_echo_off", 32'(echo_en), 32'd0);
    send(8'h55, 1'b0);
    wait_drain("t4_drain_off");
    send(8'hFF, 1'b0);
    send(8'hE2, 1'b0);
    check("t4_echo_on", 32'(echo_en), 32'd1);
    step();
    check("t4_nothing_pushed", 32'(fifo_level), 32'd0);
    send(8'h66, 1'b1);
    wait_drain("t4_drain_on");

    // double escape then mode 2, then an invalid command byte
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b1);
    check("t5_still_armed", 32'(armed), 32'd1);
    send(8'hF2, 1'b1);
    check("t5_pending", 32'(cmd_pending), 32'd1);
    wait_drain("t5_drain");
    step();
    check("t5_mode2", 32'(mode), 32'd2);
    send(8'hFF, 1'b1);
    send(8'h10, 1'b1);
    check("t5_bad_disarm",   32'(armed),       32'd0);
    check("t5_bad_nopend",   32'(cmd_pending), 32'd0);
    wait_drain("t5_drain_bad");
    step();
    step();
    check("t5_mode_unchanged", 32'(mode), 32'd2);

    // asynchronous reset mid-stream
    bus.tx_ready = 1'b0;
    send(8'hFF, 1'b1);
    send(8'hF5, 1'b1);
    send(8'hFF, 1'b1);
    send(8'hE1, 1'b1);
    check("t6_pre_echo_off", 32'(echo_en),     32'd0);
    check("t6_pre_pending",  32'(cmd_pending), 32'd1);
    send(8'hFF, 1'b0);
    check("t6_pre_armed", 32'(armed), 32'd1);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("t6_level",    32'(fifo_level),   32'd0);
    check("t6_mode",     32'(mode),         32'd1);
    check("t6_armed",    32'(armed),        32'd0);
    check("t6_pending",  32'(cmd_pending),  32'd0);
    check("t6_echo_en",  32'(echo_en),      32'd1);
    check("t6_overflow", 32'(overflow),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (3) step();
    check("t6_mode_after",    32'(mode),         32'd1);
    check("t6_tx_idle_after", 32'(bus.tx_valid), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_echo_ctrl.md
# uart_echo_ctrl

Buffered echo-and-command controller sitting between the UART receiver and transmitter in the UART top level. It echoes every received byte back through a FIFO, so back-to-back RX traffic is not lost while TX is busy. It decodes an in-band escape protocol that sets the UART mode word and controls echo. Mode changes are deferred until the echo path has drained, so no byte is ever transmitted at a half-switched setting.

## Interface
- FIFO_DEPTH, 16, echo FIFO depth in bytes; power of two, 2..256
- MODE_W, 4, width of the mode word; legal range 1..4
- MODE_RESET, 1, mode value after reset
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  reset; asynchronous and active-low
- rx_data  in  8  received byte from the RX block
- rx_valid  in  1  single-cycle strobe: rx_data valid this cycle
- tx_data  out  8  byte to transmit (FIFO head)
- tx_valid  out  1  tx_data valid; equals FIFO not empty
- tx_ready  in  1  TX block can accept a byte
- mode  out  MODE_W  current UART mode word, drives both RX and TX
- armed  out  1  escape byte received, waiting for the command byte
- cmd_pending  out  1  a decoded mode change is waiting to be applied
- echo_en  out  1  echo currently enabled
- overflow  out  1  sticky: a byte was dropped because the FIFO was full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently in the FIFO

## Operation
- Reset (async assert; release is synchronous to clk):
  - mode=MODE_RESET, armed=0, cmd_pending=0, echo_en=1, overflow=0, fifo_level=0, tx_valid=0.
  - tx_data is don't-care while tx_valid=0.
  - Pending mode and FIFO contents are discarded.
- Echo:
  - On rx_valid with echo_en=1, rx_data is pushed, including escape and command bytes.
  - With echo_en=0, nothing is pushed.
- Pop: when tx_valid && tx_ready, the head is removed.
  - tx_data is show-ahead: the next byte is presented on the following cycle.
- Push acceptance: accepted if fifo_level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - overflow stays set until an E0 command or reset.
- Pointers wrap modulo FIFO_DEPTH. fifo_level counts 0..FIFO_DEPTH.
- Command parser, evaluated on every rx_valid, independent of echo_en:
  - armed=0: byte 0xFF sets armed=1; any other byte has no effect.
  - armed=1, byte 0xFF: stays armed. This means mode value 0xF is unreachable when MODE_W=4.
  - armed=1, byte whose top (8-MODE_W) bits are all ones (and not 0xFF):
    - Pending mode is set to byte[MODE_W-1:0].
    - cmd_pending=1, armed=0.
    - A newer command overwrites an older pending one.
  - armed=1, byte 0xE0: overflow cleared, armed=0.
  - armed=1, byte 0xE1: echo_en=0, armed=0.
  - armed=1, byte 0xE2: echo_en=1, armed=0.
  - armed=1, any other byte: armed=0, no action.
- Command-byte echo: the command byte's own push uses echo_en as it was before the command took effect.
  - E1 is echoed.
  - E2 sent while echo is off is not echoed.
- Mode apply:
  - Condition: cmd_pending=1, fifo_level==0, rx_valid==0, and no push in that cycle.
  - Action: mode takes the pending value on that edge and cmd_pending clears.
  - Result: the echo of the command byte itself always leaves at the old mode.

## Timing
- rx_valid at edge N: the byte is in the FIFO after edge N. tx_valid=1 from cycle N+1 if the FIFO was empty.
- Command decode:
  - armed, cmd_pending and echo_en update on the same edge as the rx_valid byte.
  - overflow clears on that same edge.
- Mode apply: mode changes no earlier than the edge after the final pop of the command echo.
  - With tx_ready held high, that is command edge +2.
- Simultaneous push and pop at fifo_level==FIFO_DEPTH: both occur, level unchanged, no overflow.
- Simultaneous push and pop at level 0 is impossible, since tx_valid=0 at level 0.
- rst_n asserted mid-transfer: tx_valid drops immediately (asynchronously). Any in-flight TX byte is the TX block's concern.
- All outputs are registered, except tx_valid/tx_data, which decode from registered state only.

## Test plan
- After reset: mode=1, echo_en=1, level=0. Push 0x41, 0x42 with tx_ready=1 → tx_data 0x41 then 0x42, one pop per cycle, level returns to 0.
- Send 0xFF, 0xF3 with tx_ready=0:
  - Required before release: armed=1 after 0xFF; cmd_pending=1 after 0xF3; mode stays 1 while level=2.
  - Raise tx_ready: both bytes are popped, then mode=3 on the edge after the last pop, and cmd_pending=0.
- FIFO_DEPTH=4, tx_ready=0, push 6 bytes → level=4, overflow=1, first 4 bytes retained.
  - Then send 0xFF, 0xE0 → overflow=0.
  - 0xFF and 0xE0 are both dropped (FIFO still full), but the parser still acts on them.
- Send 0xFF, 0xE1, then 0x55 → 0xFF and 0xE1 echoed, 0x55 not echoed, echo_en=0.
  - Then send 0xFF, 0xE2 → neither byte echoed, echo_en=1.
- Send 0xFF, 0xFF, 0xF2 → mode=2 after drain. Send 0xFF, 0x10 → armed=0, mode unchanged.
- Full FIFO with push and pop in the same cycle → level stays FIFO_DEPTH, overflow=0.
  - Assert rst_n low mid-stream → all outputs return to reset values asynchronously.
